// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory slave controller and its storage array.
package mem_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_e;

    // Command captured from the bus when a request is accepted
    typedef struct packed {
        logic              wr_rd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage with synchronous write, registered read and synchronous clear.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_W,
    parameter int unsigned WIDTH      = DATA_W,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             hit;

    // Unimplemented words read as zero and silently drop writes
    assign hit = 32'(addr) < DEPTH;

    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we && hit) begin
                mem[addr] <= wdata;
            end
            if (re) begin
                rdata <= hit ? mem[addr] : '0;
            end
        end
    end

endmodule

// File: rtl/mem_slave_ctrl.sv
// Memory bus target: accepts one request at a time, inserts wait states, then acknowledges for one cycle.
module mem_slave_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_W,
    parameter int unsigned WIDTH       = DATA_W,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  valid,
    input  logic                  wr_rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic                  ready,
    output logic [WIDTH-1:0]      rdata,
    output logic                  addr_err,
    output logic                  proto_err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_cmd_t         cmd_q, cmd_d;
    mem_cmd_t         exe_cmd;
    logic             exec;
    logic             ready_d;
    logic             addr_err_d;
    logic             proto_err_d;
    logic             mem_we;
    logic             mem_re;

    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            ready     <= 1'b0;
            addr_err  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            ready     <= ready_d;
            addr_err  <= addr_err_d;
            proto_err <= proto_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        exe_cmd     = cmd_q;
        exec        = 1'b0;
        ready_d     = 1'b0;
        addr_err_d  = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        // Master must hold valid for the whole wait period
        proto_err_d = proto_err || ((state_q == WAIT) && !valid);

        case (state_q)
            IDLE: begin
                if (valid) begin
                    cmd_d = '{wr_rd: wr_rd, addr: addr, wdata: wdata};
                    if (WAIT_STATES > 0) begin
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                        state_d = WAIT;
                    end else begin
                        exe_cmd = cmd_d;
                        exec    = 1'b1;
                        state_d = ACK;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    exec    = 1'b1;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (exec) begin
            ready_d    = 1'b1;
            addr_err_d = !(32'(exe_cmd.addr) < DEPTH);
            mem_we     = exe_cmd.wr_rd && !addr_err_d;
            mem_re     = !exe_cmd.wr_rd;
        end
    end

    mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH)
    ) u_mem_array (
        .clk  (clk),
        .res  (res),
        .we   (mem_we),
        .re   (mem_re),
        .addr (exe_cmd.addr),
        .wdata(exe_cmd.wdata),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_mem_slave_ctrl.sv
// Scoreboard bench for mem_slave_ctrl: unit 0 has 2 wait states and 12 words, unit 1 has no wait states and 16 words.
module tb_mem_slave_ctrl;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        logic       proto;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       res;
    logic       valid    [2];
    logic       wr_rd    [2];
    logic [3:0] addr     [2];
    logic [7:0] wdata    [2];
    logic       ready    [2];
    logic [7:0] rdata    [2];
    logic       addr_err [2];
    logic       proto_err[2];

    int         ws   [2] = '{2, 0};
    int         depth[2] = '{12, 16};
    logic [7:0] mdl  [2][16];
    logic [7:0] last [2];
    logic       proto[2];
    exp_t       q0[$];
    exp_t       q1[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    mem_slave_ctrl #(.ADDR_WIDTH(4), .WIDTH(8), .DEPTH(12), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .res(res), .valid(valid[0]), .wr_rd(wr_rd[0]), .addr(addr[0]),
        .wdata(wdata[0]), .ready(ready[0]), .rdata(rdata[0]), .addr_err(addr_err[0]),
        .proto_err(proto_err[0])
    );

    mem_slave_ctrl #(.ADDR_WIDTH(4), .WIDTH(8), .DEPTH(16), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .res(res), .valid(valid[1]), .wr_rd(wr_rd[1]), .addr(addr[1]),
        .wdata(wdata[1]), .ready(ready[1]), .rdata(rdata[1]), .addr_err(addr_err[1]),
        .proto_err(proto_err[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 16; i++) mdl[u][i] = 8'h00;
            last[u]  = 8'h00;
            proto[u] = 1'b0;
        end
    endtask

    // Compare one acknowledge against the oldest outstanding expectation
    task automatic mon_pop(input int u);
        exp_t e;
        if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
            chk($sformatf("unexpected_ready_u%0d", u), 32'(ready[u]), 32'h0);
        end else begin
            e = (u == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("rdata_u%0d", u), 32'(rdata[u]), 32'(e.rdata));
            chk($sformatf("addr_err_u%0d", u), 32'(addr_err[u]), 32'(e.err));
            chk($sformatf("proto_err_u%0d", u), 32'(proto_err[u]), 32'(e.proto));
            chk($sformatf("latency_u%0d", u), 32'(cyc), 32'(e.due));
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (!res && ready[0]) mon_pop(0);
    end

    always @(negedge clk) begin
        #1;
        if (!res && ready[1]) mon_pop(1);
    end

    // Called at a negedge; returns at a negedge with valid dropped, ready for a back-to-back request
    task automatic issue(input int u, input bit wr, input logic [3:0] a, input logic [7:0] d,
                         input bit drop);
        exp_t e;
        int   n0;
        bit   seen;
        bit   in_r;
        valid[u] = 1'b1;
        wr_rd[u] = wr;
        addr[u]  = a;
        wdata[u] = d;
        @(negedge clk);
        n0 = cyc;
        if (drop && ws[u] > 0) begin
            valid[u] = 1'b0;
            addr[u]  = 4'($urandom);
            wdata[u] = 8'($urandom);
            wr_rd[u] = 1'($urandom);
            proto[u] = 1'b1;
            @(negedge clk);
            valid[u] = 1'b1;
        end
        in_r = int'(a) < depth[u];
        if (wr) begin
            if (in_r) mdl[u][a] = d;
        end else begin
            last[u] = in_r ? mdl[u][a] : 8'h00;
        end
        e.rdata = last[u];
        e.err   = !in_r;
        e.proto = proto[u];
        e.due   = n0 + ws[u];
        if (u == 0) q0.push_back(e); else q1.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (ready[u]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            chk($sformatf("ready_timeout_u%0d", u), 32'h0, 32'h1);
            if (u == 0) void'(q0.pop_back()); else void'(q1.pop_back());
        end
        @(negedge clk);
        valid[u] = 1'b0;
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            valid[u] = 1'b0;
            wr_rd[u] = 1'b0;
            addr[u]  = 4'h0;
            wdata[u] = 8'h00;
        end
        model_reset();
        res = 1'b1;
        repeat (2) @(negedge clk);
        res = 1'b0;
        for (int u = 0; u < 2; u++) begin
            chk("reset_ready", 32'(ready[u]), 32'h0);
            chk("reset_rdata", 32'(rdata[u]), 32'h0);
            chk("reset_addr_err", 32'(addr_err[u]), 32'h0);
            chk("reset_proto_err", 32'(proto_err[u]), 32'h0);
        end

        // Directed cases on the wait-state unit
        issue(0, 1'b0, 4'h3, 8'h00, 1'b0);
        issue(0, 1'b1, 4'h5, 8'hA5, 1'b0);
        issue(0, 1'b0, 4'h5, 8'h00, 1'b0);
        issue(0, 1'b1, 4'hE, 8'h3C, 1'b0);
        issue(0, 1'b0, 4'hE, 8'h00, 1'b0);
        issue(0, 1'b0, 4'h2, 8'h00, 1'b0);
        issue(0, 1'b1, 4'h1, 8'h77, 1'b1);
        issue(0, 1'b0, 4'h1, 8'h00, 1'b0);
        chk("proto_err_sticky", 32'(proto_err[0]), 32'h1);

        // Reset while a write sits in WAIT: the write must vanish
        valid[0] = 1'b1;
        wr_rd[0] = 1'b1;
        addr[0]  = 4'h6;
        wdata[0] = 8'hFF;
        @(negedge clk);
        res      = 1'b1;
        valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        res = 1'b0;
        model_reset();
        repeat (3) begin
            chk("no_ready_after_res", 32'(ready[0]), 32'h0);
            @(negedge clk);
        end
        chk("proto_err_cleared", 32'(proto_err[0]), 32'h0);
        issue(0, 1'b0, 4'h6, 8'h00, 1'b0);

        // Zero-wait unit: back-to-back fill and readback
        for (int a = 0; a < 16; a++) issue(1, 1'b1, 4'(a), 8'(a) ^ 8'h5A, 1'b0);
        for (int a = 0; a < 16; a++) issue(1, 1'b0, 4'(a), 8'h00, 1'b0);

        // Randomized traffic on both units
        repeat (80) begin
            int u;
            u = int'($urandom_range(0, 1));
            issue(u, 1'($urandom), 4'($urandom), 8'($urandom),
                  (u == 0) && ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("queue0_drained", 32'(q0.size()), 32'h0);
        chk("queue1_drained", 32'(q1.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
